// File: rtl/serial_tx_param_if.sv
// Word handshake between the core's output logic and the serial transmitter.
interface serial_tx_param_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx_param.sv
// Parametrised clock+data serial transmitter with valid/ready word intake.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_tx_param #(
  parameter int DATA_W    = 10,
  parameter int CLK_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  serial_tx_param_if.slave   tx,
  output logic               busy,
  output logic               done,
  output logic               serial_clk,
  output logic               serial_data
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(NB + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [NB-1:0]    shreg;
  logic [NB-1:0]    load_vec;
  logic [NB-1:0]    shifted;

  // Frame is laid out in transmit order: load_vec[NB-1] goes on the wire first.
  always_comb begin
    load_vec = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      load_vec[NB-1-i] = MSB_FIRST ? tx.tx_data[DATA_W-1-i] : tx.tx_data[i];
    end
`ifdef SERIAL_TX_PARITY_EN
    load_vec[0] = ^tx.tx_data;
`endif
    shifted = shreg << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx.tx_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      serial_clk  <= 1'b1;
      serial_data <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx.tx_valid && tx.tx_ready) begin
            state       <= LOW;
            shreg       <= load_vec;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx.tx_ready <= 1'b0;
            busy        <= 1'b1;
            serial_clk  <= 1'b0;
            serial_data <= load_vec[NB-1];
          end
        end
        LOW: begin
          if (div_cnt == DIV_LAST) begin
            state      <= HIGH;
            div_cnt    <= '0;
            serial_clk <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            serial_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              serial_data <= 1'b0;
            end else begin
              state       <= LOW;
              bit_cnt     <= bit_cnt + 1'b1;
              shreg       <= shifted;
              serial_data <= shifted[NB-1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          // tx_ready stays low through DONE so frames are always split by an idle-high cycle.
          state       <= IDLE;
          done        <= 1'b0;
          tx.tx_ready <= 1'b1;
          serial_clk  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_param.sv
// Bench for serial_tx_param: two configurations checked cycle by cycle against a frame model.
module tb_serial_tx_param;
  localparam int DW = 10;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = DW + PAR;
  localparam logic [4:0] IDLE_V = 5'b01010; // {busy,ready,done,sclk,sdat}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          valid_v [2];
  logic [DW-1:0] data_v  [2];
  logic          ready_v [2];
  logic          busy_v  [2];
  logic          done_v  [2];
  logic          sclk_v  [2];
  logic          sdat_v  [2];

  int compares = 0;
  int fails    = 0;

  serial_tx_param_if #(.DATA_W(DW)) if_a ();
  serial_tx_param_if #(.DATA_W(DW)) if_b ();
  assign if_a.tx_valid = valid_v[0];
  assign if_a.tx_data  = data_v[0];
  assign ready_v[0]    = if_a.tx_ready;
  assign if_b.tx_valid = valid_v[1];
  assign if_b.tx_data  = data_v[1];
  assign ready_v[1]    = if_b.tx_ready;

  serial_tx_param #(.DATA_W(DW), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .tx(if_a.slave), .busy(busy_v[0]), .done(done_v[0]),
    .serial_clk(sclk_v[0]), .serial_data(sdat_v[0])
  );
  serial_tx_param #(.DATA_W(DW), .CLK_DIV(3), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .tx(if_b.slave), .busy(busy_v[1]), .done(done_v[1]),
    .serial_clk(sclk_v[1]), .serial_data(sdat_v[1])
  );

  function automatic logic [4:0] obs(input int d);
    return {busy_v[d], ready_v[d], done_v[d], sclk_v[d], sdat_v[d]};
  endfunction

  // Bit i of the frame in wire order; dut_a sends MSB first, dut_b LSB first.
  function automatic logic exp_bit(input int d, input logic [DW-1:0] w, input int i);
    if (i >= DW) return ^w;
    return (d == 0) ? w[DW-1-i] : w[i];
  endfunction

  task automatic check5(input string tag, input logic [4:0] o, input logic [4:0] e);
    compares++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] o, input logic [15:0] e);
    compares++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Entered and left at a negedge with DUT d idle. hold keeps tx_valid high and scrambles
  // tx_data during the frame; abort_at>0 asserts rst in that busy cycle.
  task automatic run_frame(input int d, input logic [DW-1:0] w, input bit hold,
                           input int abort_at, output logic [15:0] got);
    int cd, total, ph;
    logic [4:0] e;
    logic prev;
    cd = (d == 0) ? 1 : 3;
    total = NB * 2 * cd;
    got = '0;
    prev = 1'b1;
    check5($sformatf("d%0d_idle_pre", d), obs(d), IDLE_V);
    data_v[d]  = w;
    valid_v[d] = 1'b1;
    for (int k = 1; k <= total + 2; k++) begin
      @(negedge clk);
      if (hold) data_v[d] = DW'($urandom);
      else      valid_v[d] = 1'b0;
      if (k <= total) begin
        ph = (k - 1) / cd;
        e = {3'b100, ((ph % 2) == 1), exp_bit(d, w, ph / 2)};
      end else if (k == total + 1) begin
        e = 5'b00100;
      end else begin
        e = IDLE_V;
      end
      check5($sformatf("d%0d_w%h_c%0d", d, w, k), obs(d), e);
      if (sclk_v[d] && !prev && k <= total) got = {got[14:0], sdat_v[d]};
      prev = sclk_v[d];
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check5("abort_a", obs(0), IDLE_V);
        check5("abort_b", obs(1), IDLE_V);
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [DW-1:0] w;
    int d;
    rst = 1'b1;
    valid_v[0] = 1'b0; valid_v[1] = 1'b0;
    data_v[0] = '0;    data_v[1] = '0;
    repeat (2) @(negedge clk);
    check5("reset_a", obs(0), IDLE_V);
    check5("reset_b", obs(1), IDLE_V);
    rst = 1'b0;
    @(negedge clk);
    check5("post_reset_a", obs(0), IDLE_V);

    // T1: MSB first, divider 1
    run_frame(0, 10'h2A5, 1'b0, 0, got);
`ifdef SERIAL_TX_PARITY_EN
    check16("t1_bits", got, 16'b0000010101001011);
`else
    check16("t1_bits", got, 16'b0000001010100101);
`endif
    // T2/T3: LSB first, divider 3
    run_frame(1, 10'h001, 1'b0, 0, got);
`ifdef SERIAL_TX_PARITY_EN
    check16("t2_bits", got, 16'b0000010000000001);
`else
    check16("t2_bits", got, 16'b0000001000000000);
`endif
    run_frame(1, 10'h3FF, 1'b0, 0, got);
`ifdef SERIAL_TX_PARITY_EN
    check16("t3_bits", got, 16'b0000011111111110);
`else
    check16("t3_bits", got, 16'b0000001111111111);
`endif

    // T4: tx_valid held with changing data; second accept right after done
    run_frame(0, 10'h2A5, 1'b1, 0, got);
    run_frame(0, 10'h15A, 1'b0, 0, got);
    check16("t4_second", got, {6'b0, 10'h15A} << PAR | 16'(PAR != 0 ? ^10'h15A : 1'b0));

    // T5: reset in the 7th busy cycle, then no done pulse
    run_frame(0, 10'h3C3, 1'b0, 7, got);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check5($sformatf("t5_quiet_a%0d", i), obs(0), IDLE_V);
    end
    run_frame(1, 10'h0F0, 1'b0, 9, got);

    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 1));
      w = DW'($urandom);
      run_frame(d, w, 1'(i % 3 == 0), 0, got);
      valid_v[d] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
